// File: rtl/acc_step_ctrl.sv
// acc_step_ctrl: debounced button / auto-timer step pulse generator for the ACC core
// Ports: clk, rst (async, active high); sw_next, sw_mode buttons (1 = pressed);
// core_ready (core in WAIT); step 1-cycle pulse; mode (1 = manual); pending queued
// step; step_count steps issued, wraps modulo 2^CNT_W.
module acc_step_ctrl_deb #(
  parameter int DEB_CYCLES = 32768
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic pulse_o
);
  localparam int TW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(DEB_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, WAIT_1, PULSE, WAIT_0} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic expired;
  assign expired = tmr_q == TMAX;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  always_comb begin
    state_d = state_q;
    tmr_d   = '0;
    pulse_o = 1'b0;
    case (state_q)
      IDLE:   state_d = in_i ? WAIT_1 : IDLE;
      WAIT_1: begin
        tmr_d   = expired ? '0 : tmr_q + 1'b1;
        state_d = expired ? PULSE : WAIT_1;
      end
      PULSE:  begin
        pulse_o = 1'b1;
        state_d = WAIT_0;
      end
      WAIT_0: begin
        // timer saturates while the button is still held
        tmr_d   = expired ? (in_i ? tmr_q : '0) : tmr_q + 1'b1;
        state_d = (expired && !in_i) ? IDLE : WAIT_0;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

module acc_step_ctrl #(
  parameter int DEB_CYCLES   = 32768,
  parameter int AUTO_PERIOD  = 1048576,
  parameter bit DEFAULT_MODE = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_next,
  input  logic             sw_mode,
  input  logic             core_ready,
  output logic             step,
  output logic             mode,
  output logic             pending,
  output logic [CNT_W-1:0] step_count
);
  localparam int AW = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [AW-1:0] AMAX = AW'(AUTO_PERIOD - 1);
  logic next_pulse, mode_pulse, auto_tick, src, fire;
  logic step_q, step_d, mode_q, mode_d, pending_q, pending_d;
  logic [AW-1:0] atmr_q, atmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  acc_step_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk(clk), .rst(rst), .in_i(sw_next), .pulse_o(next_pulse)
  );
  acc_step_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk(clk), .rst(rst), .in_i(sw_mode), .pulse_o(mode_pulse)
  );
  assign auto_tick = !mode_q && atmr_q == AMAX;
  assign src       = mode_q ? next_pulse : auto_tick;
  // a mode toggle swallows any same-cycle event; step_q blocks back-to-back steps
  assign fire      = !mode_pulse && core_ready && !step_q && (pending_q || src);
  always_comb begin
    atmr_d    = (mode_q || mode_pulse || auto_tick) ? '0 : atmr_q + 1'b1;
    mode_d    = mode_pulse ? ~mode_q : mode_q;
    step_d    = fire;
    pending_d = (mode_pulse || fire) ? 1'b0 : (src ? 1'b1 : pending_q);
    cnt_d     = fire ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      step_q    <= 1'b0;
      mode_q    <= DEFAULT_MODE;
      pending_q <= 1'b0;
      atmr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      step_q    <= step_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      atmr_q    <= atmr_d;
      cnt_q     <= cnt_d;
    end
  assign step       = step_q;
  assign mode       = mode_q;
  assign pending    = pending_q;
  assign step_count = cnt_q;
endmodule
